trace_reader: RTL and testbench
===============================

Name: trace_reader

Overview:
- Read-side consumer of the oscilloscope sample memory.
- On a start pulse, normally issued during vertical blanking, it walks all sample addresses and reads the 12-bit samples. It converts each sample to a screen row and stores a per-column vertical segment (ymin..ymax) that joins adjacent samples.
- During active video it compares the current pixel coordinate against the stored segment. It drives pixel_on to the display mixer.

Parameters:
- SAMPLES, 768, number of sample addresses and screen columns.
- ADDR_W, 11, sample address width.
- DATA_W, 12, sample width.
- Y_W, 10, screen row width.
- Y_SHIFT, 3, right shift applied to the inverted sample: 4095>>3 gives rows 0..511.
- Y_TOP, 16, row offset added after the shift.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a fetch pass.
- r_addr  out  ADDR_W  sample memory read address.
- dout  in  DATA_W  sample memory read data; combinational read of r_addr.
- hcount  in  11  current pixel column.
- vcount  in  Y_W  current pixel row.
- active  in  1  high in the visible region.
- busy  out  1  high while a fetch pass runs.
- done  out  1  one-cycle pulse when a pass completes.
- pixel_on  out  1  trace pixel, registered.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; r_addr=0; busy=0; done=0; pixel_on=0.
  - valid=0 and y_prev=0.
  - Buffer contents are don't-care, because valid gates them.
- Row mapping:
  - y = Y_TOP + ((4095 - dout) >> Y_SHIFT), computed at Y_W bits, unsigned.
  - dout=4095 gives row Y_TOP; dout=0 gives row Y_TOP+511.
- FSM states:
  - IDLE: start=1 clears r_addr to 0, sets busy=1, and moves to FETCH.
  - FETCH, each cycle:
    - Sample dout for the current r_addr and compute y.
    - Write column r_addr with ymin=min(y_prev,y) and ymax=max(y_prev,y).
    - For column 0, use y for both ymin and ymax.
    - Update y_prev=y.
    - If r_addr==SAMPLES-1, move to DONE; otherwise increment r_addr.
  - DONE (one cycle): done=1, busy=0, valid=1, r_addr=0, then return to IDLE.
- A full pass takes SAMPLES+1 cycles from the start edge to the done pulse: 769 cycles at the defaults.
- start while in FETCH or DONE is ignored; there is no queuing.
- r_addr never exceeds SAMPLES-1; there is no wrap inside a pass.
- Display path, one-cycle latency. pixel_on is registered as:
  - valid && active && (hcount < SAMPLES) && (ymin[hcount] <= vcount <= ymax[hcount]).
  - hcount >= SAMPLES gives 0.
  - active=0 gives 0.
- Fetch writes and display reads may occur in the same cycle. The buffer is dual-ported: one write port for fetch, one read port for display.
- Without the optional feature, columns already rewritten show new data while the rest show old data within a frame (tearing permitted).
- Reset asserted mid-pass aborts immediately: state=IDLE and valid=0, so pixel_on is 0 until the next completed pass.

Optional Feature:
- Macro: TRACE_DBUF_EN.
- Defined:
  - Two segment banks. Fetch writes the back bank; display reads the front bank.
  - The bank select toggles in the DONE cycle, so the display never shows a partial pass.
  - valid is set on the first swap.
  - Reset selects bank 0 as front.
- Undefined: single bank, behaviour as described in Behaviour, tearing allowed.

Test Plan:
- Reset then start with memory all 2048 -> busy high 768 cycles; done one cycle later (pulse 769 cycles after the start edge); r_addr steps 0..767 then returns to 0. All columns hold ymin=ymax=16+(2047>>3)=271. pixel_on=1 only at vcount=271, for hcount 0..767.
- Step data: addr<384 holds 4095, addr>=384 holds 0 -> column 384 segment is 16..527, pixel_on=1 for vcount 16..527 at hcount=384. Column 383 is row 16 only.
- Before any pass, and with hcount=800 after a pass -> pixel_on=0 in both cases. active=0 also forces pixel_on=0.
- start re-pulsed at cycle 100 of a pass -> ignored; done occurs exactly once, 769 cycles after the first start edge.
- reset pulsed low at cycle 300 of a pass -> busy=0 and r_addr=0 at once, no done pulse, pixel_on=0 until a new pass completes.
- TRACE_DBUF_EN: pass 1 with all 2048, then during pass 2 with all 0 -> display stays at row 271 for the whole of pass 2. Row 527 appears only after pass 2's done pulse.

Source files
------------

// File: rtl/trace_reader_if.sv
// trace_reader_if: fetch-control and sample-memory read bus of the trace reader.
//   start  : one-cycle pulse that begins a fetch pass (driven by the controller)
//   busy   : high while a fetch pass runs (driven by the reader)
//   done   : one-cycle pulse when a pass completes (driven by the reader)
//   r_addr : sample memory read address (driven by the reader)
//   dout   : sample memory read data, combinational read of r_addr (driven by the memory)
// Modports: master = trace reader, slave = controller / sample memory side.
interface trace_reader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] dout;

    modport master (
        input  start,
        input  dout,
        output busy,
        output done,
        output r_addr
    );

    modport slave (
        output start,
        output dout,
        input  busy,
        input  done,
        input  r_addr
    );
endinterface

// File: rtl/trace_reader.sv
// trace_reader: read-side consumer of the oscilloscope sample memory.
// A start pulse walks every sample address, maps each 12-bit sample to a screen
// row and stores a per-column vertical segment (ymin..ymax) joining adjacent
// samples. During active video the stored segment for the current column is
// compared with the pixel row to produce a registered pixel_on.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : trace_reader_if.master (start, busy, done, r_addr, dout)
//   hcount   : current pixel column
//   vcount   : current pixel row
//   active   : high in the visible region
//   pixel_on : registered trace pixel
// Optional: define TRACE_DBUF_EN for two segment banks (fetch writes the back
// bank, display reads the front bank, banks swap when a pass completes).
module trace_reader #(
    parameter int SAMPLES = 768,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 12,
    parameter int Y_W     = 10,
    parameter int Y_SHIFT = 3,
    parameter int Y_TOP   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    trace_reader_if.master        bus,
    input  logic [10:0]           hcount,
    input  logic [Y_W-1:0]        vcount,
    input  logic                  active,
    output logic                  pixel_on
);
    localparam int                IDX_W     = $clog2(SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
    localparam logic [10:0]       LAST_COL  = 11'(SAMPLES - 1);
    localparam logic [DATA_W-1:0] FULL      = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [Y_W-1:0]    y_prev, y_prev_d;
    logic [Y_W-1:0]    y;
    logic              valid;
    logic              done_q;
    logic              wr_en;
    logic [Y_W-1:0]    wr_min, wr_max;
    logic [Y_W-1:0]    rd_min, rd_max;
    logic [IDX_W-1:0]  widx, ridx;
    logic              in_range;

    // Inverted sample so full scale lands at the top row.
    assign y = Y_W'(Y_TOP) + Y_W'((FULL - bus.dout) >> Y_SHIFT);

    assign bus.r_addr = addr_q;
    assign bus.busy   = (state == FETCH);
    assign bus.done   = done_q;

    always_comb begin
        state_d  = state;
        addr_d   = addr_q;
        y_prev_d = y_prev;
        wr_en    = 1'b0;
        wr_min   = y;
        wr_max   = y;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                wr_en = 1'b1;
                // Column 0 has no left neighbour; it is a single-row segment.
                if (addr_q != '0) begin
                    wr_min = (y_prev < y) ? y_prev : y;
                    wr_max = (y_prev < y) ? y : y_prev;
                end
                y_prev_d = y;
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DONE: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TRACE_DBUF_EN
    logic bank_sel;  // front (display) bank
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            addr_q <= '0;
            y_prev <= '0;
            valid  <= 1'b0;
            done_q <= 1'b0;
`ifdef TRACE_DBUF_EN
            bank_sel <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            y_prev <= y_prev_d;
            done_q <= (state == DONE);
            if (state == DONE) begin
                valid <= 1'b1;
`ifdef TRACE_DBUF_EN
                bank_sel <= ~bank_sel;
`endif
            end
        end
    end

    assign widx     = addr_q[IDX_W-1:0];
    assign ridx     = hcount[IDX_W-1:0];
    assign in_range = (hcount <= LAST_COL);

`ifdef TRACE_DBUF_EN
    logic [Y_W-1:0] ymin_mem [2][SAMPLES];
    logic [Y_W-1:0] ymax_mem [2][SAMPLES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ymin_mem[~bank_sel][widx] <= wr_min;
            ymax_mem[~bank_sel][widx] <= wr_max;
        end
    end

    assign rd_min = ymin_mem[bank_sel][ridx];
    assign rd_max = ymax_mem[bank_sel][ridx];
`else
    logic [Y_W-1:0] ymin_mem [SAMPLES];
    logic [Y_W-1:0] ymax_mem [SAMPLES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ymin_mem[widx] <= wr_min;
            ymax_mem[widx] <= wr_max;
        end
    end

    assign rd_min = ymin_mem[ridx];
    assign rd_max = ymax_mem[ridx];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= valid && active && in_range &&
                        (rd_min <= vcount) && (vcount <= rd_max);
        end
    end
endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: scoreboard bench for trace_reader. A behavioural sample
// memory feeds dout; a segment model, committed whenever a pass completes,
// predicts pixel_on for each driven coordinate.
module tb_trace_reader;
    logic        clk;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active;
    logic        pixel_on;

    logic [11:0] tb_mem [2048];

    trace_reader_if #(.ADDR_W(11), .DATA_W(12)) bus ();

    assign bus.dout = tb_mem[bus.r_addr];

    trace_reader #(
        .SAMPLES(768), .ADDR_W(11), .DATA_W(12),
        .Y_W(10), .Y_SHIFT(3), .Y_TOP(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .hcount   (hcount),
        .vcount   (vcount),
        .active   (active),
        .pixel_on (pixel_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;
    bit exp_q [$];

    int mseg_min [768];
    int mseg_max [768];
    bit mvalid;

    function automatic int ymap(input int d);
        return 16 + ((4095 - d) >> 3);
    endfunction

    task automatic model_commit();
        int prev;
        int yy;
        prev = 0;
        for (int i = 0; i < 768; i++) begin
            yy = ymap(int'(tb_mem[i]));
            if (i == 0) begin
                mseg_min[i] = yy;
                mseg_max[i] = yy;
            end else begin
                mseg_min[i] = (prev < yy) ? prev : yy;
                mseg_max[i] = (prev < yy) ? yy : prev;
            end
            prev = yy;
        end
    endtask

    function automatic bit exp_pix(input int h, input int v, input bit a);
        if (!mvalid || !a || h >= 768) return 1'b0;
        return (mseg_min[h] <= v) && (v <= mseg_max[h]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_point(input int h, input int v, input bit a);
        hcount = 11'(h);
        vcount = 10'(v);
        active = a;
        exp_q.push_back(exp_pix(h, v, a));
    endtask

    task automatic fill_flat(input int d);
        for (int i = 0; i < 2048; i++) tb_mem[i] = 12'(d);
    endtask

    // Runs one pass; optional re-pulse of start at cycle restart_at.
    task automatic run_pass(input int restart_at, output int lat,
                            output int busy_n, output bit addr_ok);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = -1;
        busy_n = 0;
        addr_ok = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.busy === 1'b1) busy_n++;
            if (c < 768 && bus.r_addr !== 11'(c)) addr_ok = 1'b0;
            bus.start = (c == restart_at);
            step();
        end
        bus.start = 1'b0;
        if (lat >= 0) begin
            mvalid = 1'b1;
            model_commit();
        end
    endtask

    task automatic test_reset();
        bit e;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else passed++;
        total++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
        else passed++;
        total++;
        if (bus.r_addr !== 11'd0) $display("FAIL reset_r_addr: got %0d want 0", bus.r_addr);
        else passed++;
        total++;
        if (pixel_on !== 1'b0) $display("FAIL reset_pixel: got %b want 0", pixel_on);
        else passed++;
        // Before any pass the display must stay dark.
        drive_point(100, 271, 1'b1);
        step();
        e = exp_q.pop_front();
        total++;
        if (pixel_on !== e) $display("FAIL no_pass_pixel: got %b want %b", pixel_on, e);
        else passed++;
    endtask

    task automatic test_flat();
        int lat, busy_n;
        bit addr_ok, e;
        int pts [9][3] = '{'{0, 271, 1}, '{767, 271, 1}, '{383, 271, 1},
                           '{200, 270, 1}, '{200, 272, 1}, '{800, 271, 1},
                           '{768, 271, 1}, '{300, 271, 0}, '{5, 16, 1}};
        fill_flat(2048);
        run_pass(-1, lat, busy_n, addr_ok);
        total++;
        if (lat !== 769) $display("FAIL flat_latency: got %0d want 769", lat);
        else passed++;
        total++;
        if (busy_n !== 768) $display("FAIL flat_busy_cycles: got %0d want 768", busy_n);
        else passed++;
        total++;
        if (addr_ok !== 1'b1) $display("FAIL flat_addr_seq: got %b want 1", addr_ok);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL flat_busy_at_done: got %b want 0", bus.busy);
        else passed++;
        step();
        total++;
        if (bus.done !== 1'b0 || bus.r_addr !== 11'd0)
            $display("FAIL flat_after_done: got done=%b r_addr=%0d want 0 0", bus.done, bus.r_addr);
        else passed++;
        for (int i = 0; i < 9; i++) begin
            drive_point(pts[i][0], pts[i][1], pts[i][2] != 0);
            step();
            e = exp_q.pop_front();
            total++;
            if (pixel_on !== e)
                $display("FAIL flat_pixel h=%0d v=%0d a=%0d: got %b want %b",
                         pts[i][0], pts[i][1], pts[i][2], pixel_on, e);
            else passed++;
        end
    endtask

    task automatic test_step();
        int lat, busy_n;
        bit addr_ok, e;
        int pts [10][2] = '{'{384, 15}, '{384, 16}, '{384, 300}, '{384, 527},
                            '{384, 528}, '{383, 16}, '{383, 17}, '{385, 527},
                            '{385, 526}, '{0, 16}};
        for (int i = 0; i < 2048; i++) tb_mem[i] = (i < 384) ? 12'd4095 : 12'd0;
        run_pass(-1, lat, busy_n, addr_ok);
        total++;
        if (lat !== 769) $display("FAIL step_latency: got %0d want 769", lat);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            drive_point(pts[i][0], pts[i][1], 1'b1);
            step();
            e = exp_q.pop_front();
            total++;
            if (pixel_on !== e)
                $display("FAIL step_pixel h=%0d v=%0d: got %b want %b",
                         pts[i][0], pts[i][1], pixel_on, e);
            else passed++;
        end
    endtask

    task automatic test_restart_ignored();
        int lat, busy_n, extra;
        bit addr_ok;
        fill_flat(1000);
        run_pass(100, lat, busy_n, addr_ok);
        total++;
        if (lat !== 769) $display("FAIL restart_latency: got %0d want 769", lat);
        else passed++;
        total++;
        if (addr_ok !== 1'b1) $display("FAIL restart_addr_seq: got %b want 1", addr_ok);
        else passed++;
        extra = 0;
        for (int c = 0; c < 900; c++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL restart_extra_activity: got %0d want 0", extra);
        else passed++;
    endtask

    task automatic test_reset_midpass();
        int dn, lat, busy_n;
        bit addr_ok, e;
        fill_flat(2048);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 300; c++) step();
        #2 reset = 1'b0;
        mvalid = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.r_addr !== 11'd0)
            $display("FAIL midreset_abort: got busy=%b r_addr=%0d want 0 0", bus.busy, bus.r_addr);
        else passed++;
        step();
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 900; c++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
        end
        total++;
        if (dn !== 0) $display("FAIL midreset_no_done: got %0d want 0", dn);
        else passed++;
        drive_point(100, 271, 1'b1);
        step();
        e = exp_q.pop_front();
        total++;
        if (pixel_on !== e) $display("FAIL midreset_pixel_dark: got %b want %b", pixel_on, e);
        else passed++;
        run_pass(-1, lat, busy_n, addr_ok);
        total++;
        if (lat !== 769) $display("FAIL midreset_repass_latency: got %0d want 769", lat);
        else passed++;
        drive_point(100, 271, 1'b1);
        step();
        e = exp_q.pop_front();
        total++;
        if (pixel_on !== e) $display("FAIL midreset_pixel_back: got %b want %b", pixel_on, e);
        else passed++;
    endtask

`ifdef TRACE_DBUF_EN
    task automatic test_dbuf();
        int lat, busy_n, bad, got_done;
        bit addr_ok, e;
        fill_flat(2048);
        run_pass(-1, lat, busy_n, addr_ok);
        total++;
        if (lat !== 769) $display("FAIL dbuf_pass1_latency: got %0d want 769", lat);
        else passed++;
        fill_flat(0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bad = 0;
        got_done = 0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.done === 1'b1) begin
                got_done = 1;
                break;
            end
            drive_point((c * 7) % 768, (c % 2 == 0) ? 271 : 527, 1'b1);
            step();
            e = exp_q.pop_front();
            if (pixel_on !== e) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL dbuf_front_stable: got %0d wrong pixels want 0", bad);
        else passed++;
        total++;
        if (got_done !== 1) $display("FAIL dbuf_pass2_done: got %0d want 1", got_done);
        else passed++;
        model_commit();
        drive_point(50, 527, 1'b1);
        step();
        e = exp_q.pop_front();
        total++;
        if (pixel_on !== e) $display("FAIL dbuf_swap_527: got %b want %b", pixel_on, e);
        else passed++;
        drive_point(50, 271, 1'b1);
        step();
        e = exp_q.pop_front();
        total++;
        if (pixel_on !== e) $display("FAIL dbuf_swap_271: got %b want %b", pixel_on, e);
        else passed++;
    endtask
`endif

    initial begin
        total = 0;
        passed = 0;
        mvalid = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;
        hcount = '0;
        vcount = '0;
        active = 1'b0;
        fill_flat(2048);
        #23;
        test_reset();
        reset = 1'b1;
        step();
        test_reset();
        test_flat();
        test_step();
        test_restart_ignored();
        test_reset_midpass();
`ifdef TRACE_DBUF_EN
        test_dbuf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
